// File: rtl/uart_timing_frontend.sv
// Timing and strobe front end for the UART transmit path: baud enables at 8x and 1x,
// a slow periodic tick, and a synchronised, tick-sampled level detector with edge pulses.
module uart_timing_frontend #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD_SEL = 0,
    parameter int CYCLES   = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic bclk_x8,
    output logic bclk,
    output logic slow_tick,
    input  logic in,
    output logic pulse,
    output logic fall_pulse,
    output logic level
);

    // Unknown selector values fall back to the slowest rate.
    localparam int BAUD = (BAUD_SEL == 1) ? 19200 :
                          (BAUD_SEL == 2) ? 38400 :
                          (BAUD_SEL == 3) ? 115200 : 9600;
    localparam int D8   = CLK_FREQ / (8 * BAUD);
    localparam int CW8  = (D8 > 1) ? $clog2(D8) : 1;
    localparam int CWS  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    localparam logic [CW8-1:0] CNT8_MAX = CW8'(D8 - 1);
    localparam logic [CWS-1:0] SLOW_MAX = CWS'(CYCLES - 1);

    logic [CW8-1:0] cnt8_q, cnt8_d;
    logic [2:0]     sub_q, sub_d;
    logic [CWS-1:0] slow_q, slow_d;
    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic           smp_q, smp_d;
    logic           pulse_q, pulse_d;
    logic           fall_q, fall_d;

    always_comb begin
        bclk_x8   = (cnt8_q == CNT8_MAX);
        bclk      = bclk_x8 && (sub_q == 3'd7);
        slow_tick = (slow_q == SLOW_MAX);

        cnt8_d = bclk_x8 ? '0 : cnt8_q + 1'b1;
        sub_d  = bclk_x8 ? sub_q + 3'd1 : sub_q;
        slow_d = slow_tick ? '0 : slow_q + 1'b1;

        s1_d    = in;
        s2_d    = s1_q;
        smp_d   = smp_q;
        pulse_d = 1'b0;
        fall_d  = 1'b0;
        // Sampling only on the slow tick is what gives the debounce.
        if (slow_tick) begin
            smp_d   = s2_q;
            pulse_d = s2_q & ~smp_q;
            fall_d  = ~s2_q & smp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt8_q  <= '0;
            sub_q   <= '0;
            slow_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            smp_q   <= 1'b0;
            pulse_q <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt8_q  <= cnt8_d;
            sub_q   <= sub_d;
            slow_q  <= slow_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            smp_q   <= smp_d;
            pulse_q <= pulse_d;
            fall_q  <= fall_d;
        end
    end

    assign pulse      = pulse_q;
    assign fall_pulse = fall_q;
    assign level      = smp_q;

endmodule

// File: tb/tb_uart_timing_frontend.sv
// Bench for uart_timing_frontend: three instances (9600, 115200, out-of-range selector)
// share one clock and input; a reference model predicts every output each cycle.
module tb_uart_timing_frontend;

  localparam int CLK_FREQ = 100_000_000;
  localparam int CYC      = 10;
  localparam int N        = 3;
  localparam int SEL [N]  = '{0, 3, 7};

  logic clk;
  logic rst;
  logic in_sig;
  logic [6*N-1:0] act;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_timing_frontend #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD_SEL(SEL[g]),
      .CYCLES  (CYC)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bclk_x8   (act[6*g+5]),
      .bclk      (act[6*g+4]),
      .slow_tick (act[6*g+3]),
      .in        (in_sig),
      .pulse     (act[6*g+2]),
      .fall_pulse(act[6*g+1]),
      .level     (act[6*g+0])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the divisor comes straight from the baud table.
  function automatic longint d8_of(input int sel);
    int baud;
    case (sel)
      1:       baud = 19200;
      2:       baud = 38400;
      3:       baud = 115200;
      default: baud = 9600;
    endcase
    return longint'(CLK_FREQ / (8 * baud));
  endfunction

  logic [6*N-1:0] exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  longint k     = 0;
  logic  hist[$];
  logic  m_smp  = 1'b0;
  logic  m_rise = 1'b0;
  logic  m_fall = 1'b0;

  always @(posedge clk) begin
    logic [6*N-1:0] v;
    logic old_in;
    cyc++;
    if (!rst) begin
      k = 0;
      hist.delete();
      m_smp  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      // Value of the input seen two clocks earlier (zero if reset is closer).
      old_in = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      if ((k % CYC) == CYC - 1) begin
        m_rise = old_in & ~m_smp;
        m_fall = ~old_in & m_smp;
        m_smp  = old_in;
      end else begin
        m_rise = 1'b0;
        m_fall = 1'b0;
      end
      hist.push_back(in_sig);
      if (hist.size() > 4) void'(hist.pop_front());
      k++;
    end
    for (int g = 0; g < N; g++) begin
      longint d8;
      d8 = d8_of(SEL[g]);
      v[6*g+5] = ((k % d8) == d8 - 1);
      v[6*g+4] = ((k % (8 * d8)) == 8 * d8 - 1);
      v[6*g+3] = ((k % CYC) == CYC - 1);
      v[6*g+2] = m_rise;
      v[6*g+1] = m_fall;
      v[6*g+0] = m_smp;
    end
    exp_q.push_back(v);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [6*N-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, act, e);
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int total, input int max_hold);
    int left;
    int h;
    left = total;
    while (left > 0) begin
      h = $urandom_range(max_hold, 1);
      if (h > left) h = left;
      in_sig = ~in_sig;
      step(h);
      left -= h;
    end
  endtask

  task automatic check_reset_state();
    n_cmp++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset state cyc=%0d got=%b exp=all zero", cyc, act);
    end
  endtask

  task automatic wait_pulse(input int max_cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step(1);
      if (act[2] === 1'b1) seen++;
    end
    n_cmp++;
    if (seen == 0) begin
      n_fail++;
      $display("FAIL timeout: no pulse within %0d cycles, cyc=%0d", max_cyc, cyc);
    end
  endtask

  initial begin
    rst    = 1'b0;
    in_sig = 1'b1;
    step(3);
    rst = 1'b1;
    // Input held high through reset, then long random run covering several bclk periods.
    step(40);
    in_sig = 1'b0;
    step(30);
    in_sig = 1'b1;
    step(50);
    in_sig = 1'b0;
    step(5);
    in_sig = 1'b1;
    step(3);
    in_sig = 1'b0;
    step(30);
    drive_random(21000, 40);

    // Reset at slow count 6, then check the tick period restarts.
    rst = 1'b0;
    step(1);
    check_reset_state();
    rst = 1'b1;
    step(6);
    rst = 1'b0;
    step(1);
    check_reset_state();
    rst = 1'b1;
    in_sig = 1'b1;
    wait_pulse(40);

    for (int i = 0; i < 25; i++) begin
      drive_random($urandom_range(200, 20), 25);
      rst = 1'b0;
      in_sig = 1'($urandom_range(1, 0));
      step($urandom_range(3, 1));
      rst = 1'b1;
    end
    drive_random(2000, 30);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
